// File: rtl/addsub_pkg.sv
// Shared definitions for the nibble-serial add/subtract unit.
package addsub_pkg;

  localparam int unsigned NIBBLE_W = 4;
  // Nibble index width; NIBBLES is limited to 1..8, so 3 bits always suffice.
  localparam int unsigned IDX_W    = 3;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_e;

endpackage

// File: rtl/addsub4_core.sv
// Combinational 4-bit add/subtract slice. In subtract mode b is inverted and the
// caller supplies cin = 1 on the first slice. Exposes the carry into bit 3 so the
// caller can form signed overflow on the most significant slice.
module addsub4_core
  import addsub_pkg::*;
(
  input  logic [NIBBLE_W-1:0] a,
  input  logic [NIBBLE_W-1:0] b,
  input  logic                m,
  input  logic                cin,
  output logic [NIBBLE_W-1:0] sum,
  output logic                c3,
  output logic                c4
);

  logic [NIBBLE_W-1:0] bx;
  logic [3:0]          lo;
  logic [1:0]          hi;

  // Split the slice at bit 3 so the internal carry is observable.
  always_comb begin
    bx  = b ^ {NIBBLE_W{m}};
    lo  = {1'b0, a[2:0]} + {1'b0, bx[2:0]} + {3'b000, cin};
    hi  = {1'b0, a[3]} + {1'b0, bx[3]} + {1'b0, lo[3]};
    sum = {hi[0], lo[2:0]};
    c3  = lo[3];
    c4  = hi[1];
  end

endmodule

// File: rtl/multi_nibble_addsub_seq.sv
// Nibble-serial two's-complement adder/subtractor with valid/ready handshakes.
// One 4-bit slice is processed per cycle, LSB first; the result is held until
// the consumer takes it.
// Optional feature: define ADDSUB_SAT_EN to saturate s on signed overflow.
module multi_nibble_addsub_seq
  import addsub_pkg::*;
#(
  parameter int unsigned NIBBLES = 4
) (
  input  logic                        clk,
  input  logic                        rst_n,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [NIBBLES*NIBBLE_W-1:0] a,
  input  logic [NIBBLES*NIBBLE_W-1:0] b,
  input  logic                        m,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [NIBBLES*NIBBLE_W-1:0] s,
  output logic                        cout,
  output logic                        v,
  output logic                        zero
);

  localparam int unsigned W = NIBBLES * NIBBLE_W;

`ifdef ADDSUB_SAT_EN
  localparam logic [W-1:0] SatPos = {1'b0, {(W-1){1'b1}}};
  localparam logic [W-1:0] SatNeg = {1'b1, {(W-1){1'b0}}};
`endif

  state_e             state_q, state_d;
  logic [W-1:0]       a_q, a_d, b_q, b_d, s_q, s_d;
  logic               m_q, m_d;
  logic               carry_q, carry_d;
  logic               cout_q, cout_d;
  logic               v_q, v_d;
  logic [IDX_W-1:0]   idx_q, idx_d;

  logic               accept;
  logic               deliver;
  logic               last_nib;
  logic [NIBBLE_W-1:0] a_nib, b_nib, sum_nib;
  logic               c3, c4;

  assign accept   = in_valid && (state_q == IDLE);
  assign deliver  = out_ready && (state_q == DONE);
  assign last_nib = (idx_q == IDX_W'(NIBBLES - 1));

  // Select the operand nibbles addressed by the current index.
  always_comb begin
    a_nib = '0;
    b_nib = '0;
    for (int unsigned i = 0; i < NIBBLES; i++) begin
      if (idx_q == IDX_W'(i)) begin
        a_nib = a_q[i*NIBBLE_W +: NIBBLE_W];
        b_nib = b_q[i*NIBBLE_W +: NIBBLE_W];
      end
    end
  end

  addsub4_core u_core (
    .a   (a_nib),
    .b   (b_nib),
    .m   (m_q),
    .cin (carry_q),
    .sum (sum_nib),
    .c3  (c3),
    .c4  (c4)
  );

  // FSM state register.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (accept) state_d = RUN;
      RUN:     if (last_nib) state_d = DONE;
      DONE:    if (deliver) state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  // FSM outputs; zero is only meaningful while a result is presented.
  always_comb begin
    in_ready  = (state_q == IDLE);
    out_valid = (state_q == DONE);
    s         = s_q;
    cout      = cout_q;
    v         = v_q;
    zero      = out_valid && (s_q == '0);
  end

  // Datapath next-state: operand capture and per-nibble accumulation.
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    m_d     = m_q;
    s_d     = s_q;
    carry_d = carry_q;
    cout_d  = cout_q;
    v_d     = v_q;
    idx_d   = idx_q;
    if (accept) begin
      a_d     = a;
      b_d     = b;
      m_d     = m;
      idx_d   = '0;
      carry_d = m;  // +1 of the two's-complement negate in subtract mode
    end else if (state_q == RUN) begin
      for (int unsigned i = 0; i < NIBBLES; i++) begin
        if (idx_q == IDX_W'(i)) begin
          s_d[i*NIBBLE_W +: NIBBLE_W] = sum_nib;
        end
      end
      carry_d = c4;
      idx_d   = idx_q + IDX_W'(1);
      if (last_nib) begin
        cout_d = c4;
        v_d    = c3 ^ c4;
        idx_d  = '0;
`ifdef ADDSUB_SAT_EN
        // On overflow both effective operands share a sign, so the true
        // result's sign is a ^ b' ^ carry-out of the top bit.
        if (c3 ^ c4) begin
          s_d = (a_nib[3] ^ b_nib[3] ^ m_q ^ c4) ? SatNeg : SatPos;
        end
`endif
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      m_q     <= 1'b0;
      s_q     <= '0;
      carry_q <= 1'b0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      idx_q   <= '0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      m_q     <= m_d;
      s_q     <= s_d;
      carry_q <= carry_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      idx_q   <= idx_d;
    end
  end

endmodule
